// File: rtl/riscv32ima_dec_pipe.sv
// Decode stage for the riscv32ima core: lane select, immediate decode, register file
// with writeback bypass, pending-write scoreboard and a registered valid/ready output slot.
module riscv32ima_dec_pipe #(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned FETCH_DATA_WIDTH = 64,
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned REG_DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGS         = 32
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        fetch_valid,
  output logic                        fetch_ready,
  input  logic [ADDR_WIDTH-1:0]       fetch_address,
  input  logic [FETCH_DATA_WIDTH-1:0] fetch_data,
  output logic                        dec_valid,
  input  logic                        dec_ready,
  output logic [ADDR_WIDTH-1:0]       dec_pc,
  output logic [6:0]                  dec_opcode,
  output logic [2:0]                  dec_func3_opcode,
  output logic [6:0]                  dec_func7_opcode,
  output logic [REG_ADDR_WIDTH-1:0]   dec_src0_addr,
  output logic [REG_ADDR_WIDTH-1:0]   dec_src1_addr,
  output logic [REG_ADDR_WIDTH-1:0]   dec_dst_addr,
  output logic [REG_DATA_WIDTH-1:0]   dec_src0_data,
  output logic [REG_DATA_WIDTH-1:0]   dec_src1_data,
  output logic [REG_DATA_WIDTH-1:0]   dec_imm_data,
  output logic                        dec_illegal,
  input  logic                        wback_pc_wen,
  input  logic [ADDR_WIDTH-1:0]       wback_pc,
  input  logic                        wback_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0]   wback_reg_addr,
  input  logic [REG_DATA_WIDTH-1:0]   wback_reg_data
);

  localparam int unsigned LANES  = FETCH_DATA_WIDTH / 32;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_AMO      = 7'b0101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Redirect target is consumed by fetch; here only the flush strobe matters.
  logic unused_wback_pc;
  assign unused_wback_pc = ^wback_pc;

  // Output slot
  logic                      dec_valid_q, dec_valid_d;
  logic [ADDR_WIDTH-1:0]     dec_pc_q, dec_pc_d;
  logic [6:0]                dec_opcode_q, dec_opcode_d;
  logic [2:0]                dec_func3_q, dec_func3_d;
  logic [6:0]                dec_func7_q, dec_func7_d;
  logic [REG_ADDR_WIDTH-1:0] dec_src0_addr_q, dec_src0_addr_d;
  logic [REG_ADDR_WIDTH-1:0] dec_src1_addr_q, dec_src1_addr_d;
  logic [REG_ADDR_WIDTH-1:0] dec_dst_addr_q, dec_dst_addr_d;
  logic [REG_DATA_WIDTH-1:0] dec_src0_data_q, dec_src0_data_d;
  logic [REG_DATA_WIDTH-1:0] dec_src1_data_q, dec_src1_data_d;
  logic [REG_DATA_WIDTH-1:0] dec_imm_q, dec_imm_d;
  logic                      dec_illegal_q, dec_illegal_d;
  logic                      dec_wr_rd_q, dec_wr_rd_d;

  logic [REG_DATA_WIDTH-1:0] rf_q [NUM_REGS];
  logic [REG_DATA_WIDTH-1:0] rf_d [NUM_REGS];
  logic [NUM_REGS-1:0]       busy_q, busy_d;

  logic [LANE_W-1:0]         lane;
  logic [31:0]               inst;
  logic [6:0]                opc;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [31:0]               imm;
  logic                      illegal, use_rs1, use_rs2, wr_class, wr_rd;
  logic [REG_DATA_WIDTH-1:0] src0_data, src1_data;
  logic                      haz_rs1, haz_rs2, hazard;
  logic                      fetch_ready_c, accept, dec_hs;

  // Pick the 32-bit lane addressed by the PC
  always_comb begin
    lane = '0;
    if (LANES > 1) lane = fetch_address[2 +: LANE_W];
    inst = fetch_data[31:0];
    for (int unsigned i = 1; i < LANES; i++) begin
      if (lane == LANE_W'(i)) inst = fetch_data[32*i +: 32];
    end
  end

  always_comb begin
    opc      = inst[6:0];
    rs1      = REG_ADDR_WIDTH'(inst[19:15]);
    rs2      = REG_ADDR_WIDTH'(inst[24:20]);
    rd       = REG_ADDR_WIDTH'(inst[11:7]);
    imm      = '0;
    illegal  = 1'b0;
    use_rs1  = 1'b1;
    use_rs2  = 1'b0;
    wr_class = 1'b0;
    unique case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
        imm      = {{20{inst[31]}}, inst[31:20]};
        wr_class = 1'b1;
      end
      OPC_STORE: begin
        imm     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        imm     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        use_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm      = {inst[31:12], 12'h000};
        use_rs1  = 1'b0;
        wr_class = 1'b1;
      end
      OPC_JAL: begin
        imm      = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        use_rs1  = 1'b0;
        wr_class = 1'b1;
      end
      OPC_OP, OPC_AMO: begin
        use_rs2  = 1'b1;
        wr_class = 1'b1;
      end
      OPC_MISC_MEM: ;
      default: illegal = 1'b1;
    endcase
    wr_rd = wr_class && (rd != '0);
  end

  // Operand read with same-cycle writeback bypass; x0 always reads zero
  always_comb begin
    src0_data = rf_q[rs1];
    src1_data = rf_q[rs2];
    if (wback_reg_wen && (wback_reg_addr == rs1)) src0_data = wback_reg_data;
    if (wback_reg_wen && (wback_reg_addr == rs2)) src1_data = wback_reg_data;
    if (rs1 == '0) src0_data = '0;
    if (rs2 == '0) src1_data = '0;
  end

  // A source is blocked by an older pending write unless that write lands this cycle,
  // or by the held instruction which has not yet set its scoreboard bit.
  always_comb begin
    haz_rs1 = (busy_q[rs1] && !(wback_reg_wen && (wback_reg_addr == rs1))) ||
              (dec_valid_q && dec_wr_rd_q && (dec_dst_addr_q == rs1));
    haz_rs2 = (busy_q[rs2] && !(wback_reg_wen && (wback_reg_addr == rs2))) ||
              (dec_valid_q && dec_wr_rd_q && (dec_dst_addr_q == rs2));
    hazard  = (use_rs1 && (rs1 != '0) && haz_rs1) || (use_rs2 && (rs2 != '0) && haz_rs2);
    fetch_ready_c = (!dec_valid_q || dec_ready) && !hazard && !wback_pc_wen;
    accept        = fetch_valid && fetch_ready_c;
    dec_hs        = dec_valid_q && dec_ready;
  end

  always_comb begin
    rf_d = rf_q;
    if (wback_reg_wen && (wback_reg_addr != '0)) rf_d[wback_reg_addr] = wback_reg_data;
  end

  // Clear first so a same-cycle set on the same register wins
  always_comb begin
    busy_d = busy_q;
    if (wback_reg_wen) busy_d[wback_reg_addr] = 1'b0;
    if (dec_hs && dec_wr_rd_q) busy_d[dec_dst_addr_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    dec_valid_d     = dec_valid_q;
    dec_pc_d        = dec_pc_q;
    dec_opcode_d    = dec_opcode_q;
    dec_func3_d     = dec_func3_q;
    dec_func7_d     = dec_func7_q;
    dec_src0_addr_d = dec_src0_addr_q;
    dec_src1_addr_d = dec_src1_addr_q;
    dec_dst_addr_d  = dec_dst_addr_q;
    dec_src0_data_d = dec_src0_data_q;
    dec_src1_data_d = dec_src1_data_q;
    dec_imm_d       = dec_imm_q;
    dec_illegal_d   = dec_illegal_q;
    dec_wr_rd_d     = dec_wr_rd_q;
    if (accept) begin
      dec_valid_d     = 1'b1;
      dec_pc_d        = fetch_address;
      dec_opcode_d    = opc;
      dec_func3_d     = inst[14:12];
      dec_func7_d     = inst[31:25];
      dec_src0_addr_d = rs1;
      dec_src1_addr_d = rs2;
      dec_dst_addr_d  = rd;
      dec_src0_data_d = src0_data;
      dec_src1_data_d = src1_data;
      dec_imm_d       = REG_DATA_WIDTH'(imm);
      dec_illegal_d   = illegal;
      dec_wr_rd_d     = wr_rd;
    end else if (dec_hs) begin
      dec_valid_d = 1'b0;
    end
    if (wback_pc_wen) dec_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dec_valid_q     <= 1'b0;
      dec_pc_q        <= '0;
      dec_opcode_q    <= '0;
      dec_func3_q     <= '0;
      dec_func7_q     <= '0;
      dec_src0_addr_q <= '0;
      dec_src1_addr_q <= '0;
      dec_dst_addr_q  <= '0;
      dec_src0_data_q <= '0;
      dec_src1_data_q <= '0;
      dec_imm_q       <= '0;
      dec_illegal_q   <= 1'b0;
      dec_wr_rd_q     <= 1'b0;
      busy_q          <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      dec_valid_q     <= dec_valid_d;
      dec_pc_q        <= dec_pc_d;
      dec_opcode_q    <= dec_opcode_d;
      dec_func3_q     <= dec_func3_d;
      dec_func7_q     <= dec_func7_d;
      dec_src0_addr_q <= dec_src0_addr_d;
      dec_src1_addr_q <= dec_src1_addr_d;
      dec_dst_addr_q  <= dec_dst_addr_d;
      dec_src0_data_q <= dec_src0_data_d;
      dec_src1_data_q <= dec_src1_data_d;
      dec_imm_q       <= dec_imm_d;
      dec_illegal_q   <= dec_illegal_d;
      dec_wr_rd_q     <= dec_wr_rd_d;
      busy_q          <= busy_d;
      rf_q            <= rf_d;
    end
  end

  assign fetch_ready      = fetch_ready_c;
  assign dec_valid        = dec_valid_q;
  assign dec_pc           = dec_pc_q;
  assign dec_opcode       = dec_opcode_q;
  assign dec_func3_opcode = dec_func3_q;
  assign dec_func7_opcode = dec_func7_q;
  assign dec_src0_addr    = dec_src0_addr_q;
  assign dec_src1_addr    = dec_src1_addr_q;
  assign dec_dst_addr     = dec_dst_addr_q;
  assign dec_src0_data    = dec_src0_data_q;
  assign dec_src1_data    = dec_src1_data_q;
  assign dec_imm_data     = dec_imm_q;
  assign dec_illegal      = dec_illegal_q;

endmodule
